// File: rtl/hex_counter_pkg.sv
// Shared rate encodings and the clock-cycle period for each rate selection.
package hex_counter_pkg;

    typedef enum logic [1:0] {
        RATE_FULL = 2'b00,
        RATE_1S   = 2'b01,
        RATE_2S   = 2'b10,
        RATE_4S   = 2'b11
    } rate_e;

    localparam int unsigned RATE_W = 2;
    localparam int unsigned VALUE_W = 4;

    // Number of clock cycles between increments for a given rate.
    function automatic int unsigned period(input rate_e rate_sel, input int unsigned clk_hz);
        int unsigned p;
        p = 1;
        case (rate_sel)
            RATE_FULL: p = 1;
            RATE_1S:   p = clk_hz;
            RATE_2S:   p = clk_hz * 32'd2;
            RATE_4S:   p = clk_hz * 32'd4;
            default:   p = 1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hex_rate_counter_rate_divider.sv
// Selectable-rate down-counting divider; pulse marks an edge on which the counter advances.
module rate_divider
    import hex_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = $clog2(4 * CLK_HZ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate_sel,
    input  logic              clear,
    output logic              pulse
);

    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  reload;
    logic [RATE_W-1:0] rate_q;
    logic              rate_changed;

    assign reload       = DIV_W'(period(rate_e'(rate_sel), CLK_HZ) - 32'd1);
    assign rate_changed = (rate_sel != rate_q);

    // Load and rate change both outrank a terminal count, so neither can yield a pulse.
    assign pulse = enable && !clear && !rate_changed && (div == '0);

    // Reset seeds the divider from the live selection so the first period is full length.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div    <= reload;
            rate_q <= rate_sel;
        end else begin
            rate_q <= rate_sel;
            if (clear || rate_changed) begin
                div <= reload;
            end else if (enable) begin
                if (div == '0) begin
                    div <= reload;
                end else begin
                    div <= div - DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hex_rate_counter.sv
// 4-bit wrap-around hex counter with parallel load, advanced at a selectable rate.
module hex_rate_counter
    import hex_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = $clog2(4 * CLK_HZ)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic [RATE_W-1:0]  rate_sel,
    input  logic               par_load,
    input  logic [VALUE_W-1:0] load_val,
    output logic [VALUE_W-1:0] value,
    output logic               tick
);

    logic pulse;

    rate_divider #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_rate_divider (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .rate_sel (rate_sel),
        .clear    (par_load),
        .pulse    (pulse)
    );

    // Load wins over an increment; tick accompanies the newly visible value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
            tick  <= 1'b0;
        end else if (par_load) begin
            value <= load_val;
            tick  <= 1'b0;
        end else if (pulse) begin
            value <= value + VALUE_W'(1);
            tick  <= 1'b1;
        end else begin
            tick  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hex_rate_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an enabled-edge model.
module tb_hex_rate_counter;

    localparam int unsigned CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [1:0] rate_sel;
    logic       par_load;
    logic [3:0] load_val;
    logic [3:0] value;
    logic       tick;

    int vectors     = 0;
    int miscompares = 0;

    // Model: enabled edges remaining until the next increment.
    int unsigned m_rem;
    logic [3:0]  m_value;
    logic        m_tick;
    logic [1:0]  m_rate;

    hex_rate_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .rate_sel (rate_sel),
        .par_load (par_load),
        .load_val (load_val),
        .value    (value),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    function automatic int unsigned p_of(input logic [1:0] r);
        case (r)
            2'b00:   return 1;
            2'b01:   return CLK_HZ;
            2'b10:   return 2 * CLK_HZ;
            default: return 4 * CLK_HZ;
        endcase
    endfunction

    task automatic model_reset();
        m_value = 4'h0;
        m_tick  = 1'b0;
        m_rate  = rate_sel;
        m_rem   = p_of(rate_sel);
    endtask

    // Advance one rising edge, update the model from the inputs seen at that edge, settle.
    task automatic step();
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else if (par_load) begin
            m_value = load_val;
            m_rem   = p_of(rate_sel);
            m_tick  = 1'b0;
        end else if (rate_sel != m_rate) begin
            m_rem  = p_of(rate_sel);
            m_tick = 1'b0;
        end else if (enable) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_value = m_value + 4'd1;
                m_rem   = p_of(rate_sel);
                m_tick  = 1'b1;
            end else begin
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        m_rate = rate_sel;
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (value !== 4'h0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init: value=%h tick=%b expected value=0 tick=0", value, tick);
        end
        rate_sel = 2'b01;
        step();
        resetn = 1'b1;
        model_reset();
        par_load = 1'b1;
        load_val = 4'h7;
        step();
        par_load = 1'b0;
        enable   = 1'b1;
        step();
        step();
        vectors++;
        if (value !== 4'h7) begin
            miscompares++;
            $display("FAIL reset_preload: value=%h expected 7", value);
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (value !== 4'h0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: value=%h tick=%b expected value=0 tick=0", value, tick);
        end
        step();
    endtask

    task automatic test_rate01();
        logic [3:0] exp_v;
        logic       exp_t;
        rate_sel = 2'b01;
        enable   = 1'b1;
        resetn   = 1'b1;
        model_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_v = 4'(i / 4);
            exp_t = (i == 4 || i == 8);
            vectors++;
            if (value !== exp_v || tick !== exp_t || value !== m_value || tick !== m_tick) begin
                miscompares++;
                $display("FAIL rate01 edge %0d: value=%h tick=%b expected value=%h tick=%b",
                         i, value, tick, exp_v, exp_t);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_v [4];
        logic       exp_t [4];
        exp_v = '{4'hE, 4'hF, 4'h0, 4'h1};
        exp_t = '{1'b0, 1'b1, 1'b1, 1'b1};
        rate_sel = 2'b00;
        par_load = 1'b1;
        load_val = 4'hE;
        for (int i = 0; i < 4; i++) begin
            step();
            par_load = 1'b0;
            vectors++;
            if (value !== exp_v[i] || tick !== exp_t[i]) begin
                miscompares++;
                $display("FAIL wrap step %0d: value=%h tick=%b expected value=%h tick=%b",
                         i, value, tick, exp_v[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_load_while_counting();
        rate_sel = 2'b10;
        enable   = 1'b1;
        step();
        for (int k = 0; k < 20 && m_rem != 1; k++) step();
        vectors++;
        if (m_rem != 1) begin
            miscompares++;
            $display("FAIL load_reach_terminal: remaining=%0d expected 1", m_rem);
        end
        par_load = 1'b1;
        load_val = 4'h9;
        step();
        par_load = 1'b0;
        vectors++;
        if (value !== 4'h9 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL load_at_terminal: value=%h tick=%b expected value=9 tick=0", value, tick);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            vectors++;
            if (value !== ((i == 8) ? 4'hA : 4'h9) || tick !== (i == 8)) begin
                miscompares++;
                $display("FAIL load_then_count edge %0d: value=%h tick=%b", i, value, tick);
            end
        end
    endtask

    task automatic test_rate_change();
        logic [3:0] v0;
        rate_sel = 2'b11;
        enable   = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        v0 = m_value;
        rate_sel = 2'b01;
        step();
        vectors++;
        if (value !== v0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL rate_switch_edge: value=%h tick=%b expected value=%h tick=0", value, tick, v0);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (value !== ((i == 4) ? v0 + 4'd1 : v0) || tick !== (i == 4)) begin
                miscompares++;
                $display("FAIL rate_switch_count edge %0d: value=%h tick=%b", i, value, tick);
            end
        end
    endtask

    task automatic test_enable_gap();
        logic [3:0] v0;
        rate_sel = 2'b01;
        enable   = 1'b1;
        par_load = 1'b1;
        load_val = 4'(($urandom % 16));
        step();
        par_load = 1'b0;
        v0 = load_val;
        step();
        step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (value !== v0 || tick !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_hold %0d: value=%h tick=%b expected value=%h tick=0", i, value, tick, v0);
            end
        end
        enable = 1'b1;
        step();
        vectors++;
        if (value !== v0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_resume1: value=%h expected %h", value, v0);
        end
        step();
        vectors++;
        if (value !== v0 + 4'd1 || tick !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_resume2: value=%h tick=%b expected value=%h tick=1", value, tick, v0 + 4'd1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            enable   = ($urandom_range(0, 3) != 0);
            par_load = ($urandom_range(0, 31) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) rate_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                #2;
                resetn = 1'b0;
                model_reset();
                #1;
                vectors++;
                if (value !== 4'h0 || tick !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random_reset %0d: value=%h tick=%b expected 0/0", n, value, tick);
                end
                step();
                resetn = 1'b1;
                model_reset();
            end else begin
                step();
                vectors++;
                if (value !== m_value || tick !== m_tick) begin
                    miscompares++;
                    $display("FAIL random %0d: value=%h tick=%b expected value=%h tick=%b",
                             n, value, tick, m_value, m_tick);
                end
            end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        enable   = 1'b0;
        par_load = 1'b0;
        rate_sel = 2'b00;
        load_val = 4'h0;
        model_reset();
        test_reset();
        test_rate01();
        test_wrap();
        test_load_while_counting();
        test_rate_change();
        test_enable_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
